// File: rtl/mem_stage_hs.sv
// Memory-access stage between EX and WB: variable-latency req/ack data-memory port, big-endian byte enables.
// Optional macro MEM_UNALIGNED_EN enables LWL/LWR/SWL/SWR; without it those ops raise addr_err.
module mem_stage_hs #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       Instr_IN,
  input  logic [31:0]       PC_IN,
  input  logic [ADDR_W-1:0] ALU_result_IN,
  input  logic [31:0]       MemWriteData_IN,
  input  logic [4:0]        WriteRegister_IN,
  input  logic              RegWrite_IN,
  input  logic              MemRead_IN,
  input  logic              MemWrite_IN,
  input  logic [5:0]        ALU_Control_IN,
  output logic              out_valid,
  output logic [31:0]       Instr_OUT,
  output logic [31:0]       PC_OUT,
  output logic [4:0]        WriteRegister_OUT,
  output logic              RegWrite_OUT,
  output logic [31:0]       WriteData_OUT,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic [3:0]        dm_be,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic              addr_err,
  output logic              timeout_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

`ifdef MEM_UNALIGNED_EN
  localparam logic UNALIGNED_EN = 1'b1;
`else
  localparam logic UNALIGNED_EN = 1'b0;
`endif

  localparam logic [5:0] OP_LB   = 6'b100001;
  localparam logic [5:0] OP_LBU  = 6'b101010;
  localparam logic [5:0] OP_LH   = 6'b101011;
  localparam logic [5:0] OP_LHU  = 6'b101100;
  localparam logic [5:0] OP_LW   = 6'b111101;
  localparam logic [5:0] OP_LL   = 6'b101000;
  localparam logic [5:0] OP_LWC1 = 6'b110101;
  localparam logic [5:0] OP_LWL  = 6'b101101;
  localparam logic [5:0] OP_LWR  = 6'b101110;
  localparam logic [5:0] OP_SB   = 6'b101111;
  localparam logic [5:0] OP_SH   = 6'b110000;
  localparam logic [5:0] OP_SW   = 6'b110001;
  localparam logic [5:0] OP_SC   = 6'b110110;
  localparam logic [5:0] OP_SWL  = 6'b110010;
  localparam logic [5:0] OP_SWR  = 6'b110011;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q;
  logic [31:0]       instr_q, instr_d, pc_q, pc_d, rt_q, rt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]        wreg_q, wreg_d;
  logic              regw_q, regw_d, we_q, we_d;
  logic [5:0]        op_q, op_d;
  logic              out_valid_q, out_valid_d, addr_err_q, addr_err_d;
  logic              timeout_err_q, timeout_err_d;
  logic [31:0]       wd_out_q, wd_out_d, instr_out_q, instr_out_d, pc_out_q, pc_out_d;
  logic              regw_out_q, regw_out_d;
  logic [4:0]        wreg_out_q, wreg_out_d;

  logic [1:0]  in_off, off_q;
  logic        in_legal, in_store, in_misal, in_mem;
  logic        access;
  logic [3:0]  be_acc;
  logic [31:0] wdata_acc, alu_ext, rd_right, lr_mask, rd_half, ld_result;
  logic [7:0]  rd_byte;

  assign access  = (state_q == S_ACCESS);
  assign off_q   = addr_q[1:0];
  assign in_off  = ALU_result_IN[1:0];
  assign in_mem  = MemRead_IN | MemWrite_IN;
  assign alu_ext = 32'(addr_q);

  // Incoming op classification: store direction, alignment, and legality.
  always_comb begin
    in_legal = 1'b1;
    in_store = 1'b0;
    in_misal = 1'b0;
    case (ALU_Control_IN)
      OP_LB, OP_LBU:         ;
      OP_LH, OP_LHU:         in_misal = in_off[0];
      OP_LW, OP_LL, OP_LWC1: in_misal = (in_off != 2'd0);
      OP_LWL, OP_LWR:        in_legal = UNALIGNED_EN;
      OP_SB:                 in_store = 1'b1;
      OP_SH: begin
        in_store = 1'b1;
        in_misal = in_off[0];
      end
      OP_SW, OP_SC: begin
        in_store = 1'b1;
        in_misal = (in_off != 2'd0);
      end
      OP_SWL, OP_SWR: begin
        in_store = 1'b1;
        in_legal = UNALIGNED_EN;
      end
      default:               in_legal = 1'b0;
    endcase
  end

  // Byte-lane enables and store data for the outstanding request.
  always_comb begin
    be_acc    = 4'b1111;
    wdata_acc = rt_q;
    case (op_q)
      OP_LB, OP_LBU, OP_SB: begin
        be_acc    = 4'b1000 >> off_q;
        wdata_acc = {4{rt_q[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        be_acc    = 4'b1100 >> off_q;
        wdata_acc = {2{rt_q[15:0]}};
      end
      OP_LWL, OP_SWL: begin
        be_acc    = 4'b1111 >> off_q;
        wdata_acc = rt_q >> {off_q, 3'b000};
      end
      OP_LWR, OP_SWR: begin
        be_acc    = 4'b1111 << (~off_q);
        wdata_acc = rt_q << {~off_q, 3'b000};
      end
      default: ;
    endcase
  end

  // Big-endian: shifting right by 8*(3-o) brings byte o into the low lane.
  assign rd_right = dm_rdata >> {~off_q, 3'b000};
  assign rd_byte  = rd_right[7:0];
  assign rd_half  = {16'h0000, (off_q[1] ? dm_rdata[15:0] : dm_rdata[31:16])};
  assign lr_mask  = 32'hFFFF_FFFF >> {~off_q, 3'b000};

  always_comb begin
    ld_result = alu_ext;
    case (op_q)
      OP_LB:                 ld_result = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:                ld_result = {24'h000000, rd_byte};
      OP_LH:                 ld_result = {{16{rd_half[15]}}, rd_half[15:0]};
      OP_LHU:                ld_result = rd_half;
      OP_LW, OP_LL, OP_LWC1: ld_result = dm_rdata;
      OP_LWL:                ld_result = (dm_rdata << {off_q, 3'b000}) |
                                         (rt_q & ~(32'hFFFF_FFFF << {off_q, 3'b000}));
      OP_LWR:                ld_result = (rt_q & ~lr_mask) | rd_right;
      OP_SC:                 ld_result = 32'd1;
      default:               ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    addr_d        = addr_q;
    rt_d          = rt_q;
    wreg_d        = wreg_q;
    regw_d        = regw_q;
    op_d          = op_q;
    we_d          = we_q;
    out_valid_d   = 1'b0;
    addr_err_d    = 1'b0;
    timeout_err_d = 1'b0;
    wd_out_d      = wd_out_q;
    regw_out_d    = regw_out_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          instr_d = Instr_IN;
          pc_d    = PC_IN;
          addr_d  = ALU_result_IN;
          rt_d    = MemWriteData_IN;
          wreg_d  = WriteRegister_IN;
          regw_d  = RegWrite_IN;
          op_d    = ALU_Control_IN;
          we_d    = in_store;
          cnt_d   = '0;
          if (!in_mem) begin
            state_d     = S_RESP;
            out_valid_d = 1'b1;
            wd_out_d    = 32'(ALU_result_IN);
            regw_out_d  = RegWrite_IN;
          end else if (!in_legal || in_misal) begin
            state_d     = S_RESP;
            out_valid_d = 1'b1;
            addr_err_d  = 1'b1;
            wd_out_d    = 32'(ALU_result_IN);
            regw_out_d  = 1'b0;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        // An ack in the final timeout cycle still completes normally.
        if (dm_ack) begin
          state_d     = S_RESP;
          out_valid_d = 1'b1;
          wd_out_d    = ld_result;
          regw_out_d  = regw_q;
        end else if (cnt_q >= CNT_LAST) begin
          state_d       = S_RESP;
          out_valid_d   = 1'b1;
          timeout_err_d = 1'b1;
          wd_out_d      = 32'd0;
          regw_out_d    = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign instr_out_d = out_valid_d ? instr_d : instr_out_q;
  assign pc_out_d    = out_valid_d ? pc_d    : pc_out_q;
  assign wreg_out_d  = out_valid_d ? wreg_d  : wreg_out_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      in_ready_q    <= 1'b0;
      instr_q       <= '0;
      pc_q          <= '0;
      addr_q        <= '0;
      rt_q          <= '0;
      wreg_q        <= '0;
      regw_q        <= 1'b0;
      op_q          <= '0;
      we_q          <= 1'b0;
      out_valid_q   <= 1'b0;
      addr_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      wd_out_q      <= '0;
      regw_out_q    <= 1'b0;
      wreg_out_q    <= '0;
      instr_out_q   <= '0;
      pc_out_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      in_ready_q    <= (state_d == S_IDLE);
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      addr_q        <= addr_d;
      rt_q          <= rt_d;
      wreg_q        <= wreg_d;
      regw_q        <= regw_d;
      op_q          <= op_d;
      we_q          <= we_d;
      out_valid_q   <= out_valid_d;
      addr_err_q    <= addr_err_d;
      timeout_err_q <= timeout_err_d;
      wd_out_q      <= wd_out_d;
      regw_out_q    <= regw_out_d;
      wreg_out_q    <= wreg_out_d;
      instr_out_q   <= instr_out_d;
      pc_out_q      <= pc_out_d;
    end
  end

  assign in_ready          = in_ready_q;
  assign out_valid         = out_valid_q;
  assign addr_err          = addr_err_q;
  assign timeout_err       = timeout_err_q;
  assign WriteData_OUT     = wd_out_q;
  assign RegWrite_OUT      = regw_out_q;
  assign WriteRegister_OUT = wreg_out_q;
  assign Instr_OUT         = instr_out_q;
  assign PC_OUT            = pc_out_q;
  assign dm_req            = access;
  assign dm_we             = access & we_q;
  assign dm_be             = access ? be_acc : 4'b0000;
  assign dm_addr           = {addr_q[ADDR_W-1:2], 2'b00};
  assign dm_wdata          = wdata_acc;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs (TIMEOUT=4); unaligned-op expectations follow MEM_UNALIGNED_EN.
module tb_mem_stage_hs;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        in_valid, in_ready;
  logic [31:0] Instr_IN, PC_IN, ALU_result_IN, MemWriteData_IN;
  logic [4:0]  WriteRegister_IN;
  logic        RegWrite_IN, MemRead_IN, MemWrite_IN;
  logic [5:0]  ALU_Control_IN;
  logic        out_valid;
  logic [31:0] Instr_OUT, PC_OUT, WriteData_OUT;
  logic [4:0]  WriteRegister_OUT;
  logic        RegWrite_OUT;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        addr_err, timeout_err;

  int checks   = 0;
  int failures = 0;

  mem_stage_hs #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_ready(in_ready),
    .Instr_IN(Instr_IN), .PC_IN(PC_IN),
    .ALU_result_IN(ALU_result_IN), .MemWriteData_IN(MemWriteData_IN),
    .WriteRegister_IN(WriteRegister_IN), .RegWrite_IN(RegWrite_IN),
    .MemRead_IN(MemRead_IN), .MemWrite_IN(MemWrite_IN),
    .ALU_Control_IN(ALU_Control_IN),
    .out_valid(out_valid), .Instr_OUT(Instr_OUT), .PC_OUT(PC_OUT),
    .WriteRegister_OUT(WriteRegister_OUT), .RegWrite_OUT(RegWrite_OUT),
    .WriteData_OUT(WriteData_OUT),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .addr_err(addr_err), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Presents one op for a single cycle; it is accepted at the next edge.
  task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                       input logic [4:0] wr, input logic rw, input logic mr, input logic mw,
                       input logic [31:0] pc);
    in_valid         = 1'b1;
    ALU_Control_IN   = op;
    ALU_result_IN    = addr;
    MemWriteData_IN  = rt;
    WriteRegister_IN = wr;
    RegWrite_IN      = rw;
    MemRead_IN       = mr;
    MemWrite_IN      = mw;
    Instr_IN         = {op, 26'h0ABCDE};
    PC_IN            = pc;
    tick();
    in_valid = 1'b0;
    $display("issue op=%b addr=0x%08h rt=0x%08h pc=0x%08h", op, addr, rt, pc);
  endtask

  initial begin
    RESET = 1'b0;
    in_valid = 1'b0; Instr_IN = '0; PC_IN = '0; ALU_result_IN = '0; MemWriteData_IN = '0;
    WriteRegister_IN = '0; RegWrite_IN = 1'b0; MemRead_IN = 1'b0; MemWrite_IN = 1'b0;
    ALU_Control_IN = '0; dm_ack = 1'b0; dm_rdata = '0;

    // Reset state
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_dm_req", dm_req, 0);
    chk("rst_wdata_out", WriteData_OUT, 0);
    RESET = 1'b1;
    #2;
    chk("rel_in_ready_low", in_ready, 0);
    tick();
    chk("rel_in_ready_high", in_ready, 1);

    // ADD: result 0x1234 to reg 5
    issue(6'b100000, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0000_0400);
    chk("add_out_valid", out_valid, 1);
    chk("add_wdata", WriteData_OUT, 32'h0000_1234);
    chk("add_wreg", WriteRegister_OUT, 5);
    chk("add_regwrite", RegWrite_OUT, 1);
    chk("add_pc", PC_OUT, 32'h0000_0400);
    chk("add_dm_req", dm_req, 0);
    chk("add_in_ready", in_ready, 0);
    tick();
    chk("add_pulse_end", out_valid, 0);
    chk("add_hold", WriteData_OUT, 32'h0000_1234);
    chk("add_ready_back", in_ready, 1);

    // Ack with no request outstanding is ignored
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    chk("stray_ack_valid", out_valid, 0);
    chk("stray_ack_req", dm_req, 0);

    // LB at 0x1001, three wait cycles, then ack
    issue(6'b100001, 32'h0000_1001, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 32'h0000_0404);
    dm_rdata = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      chk("lb_wait_req", dm_req, 1);
      chk("lb_wait_ready", in_ready, 0);
      chk("lb_wait_valid", out_valid, 0);
      tick();
    end
    chk("lb_addr", dm_addr, 32'h0000_1000);
    chk("lb_we", dm_we, 0);
    dm_ack = 1'b1; dm_rdata = 32'h11F2_3344;
    tick();
    dm_ack = 1'b0; dm_rdata = 32'h0;
    chk("lb_out_valid", out_valid, 1);
    chk("lb_wdata", WriteData_OUT, 32'hFFFF_FFF2);
    chk("lb_wreg", WriteRegister_OUT, 7);
    chk("lb_ready_low", in_ready, 0);
    chk("lb_req_drop", dm_req, 0);
    tick();
    chk("lb_ready_back", in_ready, 1);

    // SH at 0x2002, rt=0xAAAABEEF, zero-wait ack
    issue(6'b110000, 32'h0000_2002, 32'hAAAA_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0408);
    chk("sh_req", dm_req, 1);
    chk("sh_we", dm_we, 1);
    chk("sh_be", dm_be, 4'b0011);
    chk("sh_wdata", dm_wdata, 32'hBEEF_BEEF);
    chk("sh_addr", dm_addr, 32'h0000_2000);
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    chk("sh_out_valid", out_valid, 1);
    chk("sh_regwrite", RegWrite_OUT, 0);
    tick();

    // SB at offset 3, then SC (WriteData = 1)
    issue(6'b101111, 32'h0000_2103, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_040C);
    chk("sb_be", dm_be, 4'b0001);
    chk("sb_wdata", dm_wdata, 32'h7878_7878);
    dm_ack = 1'b1; tick(); dm_ack = 1'b0;
    tick();
    issue(6'b110110, 32'h0000_4000, 32'h1234_5678, 5'd9, 1'b1, 1'b0, 1'b1, 32'h0000_0410);
    chk("sc_be", dm_be, 4'b1111);
    chk("sc_wdata", dm_wdata, 32'h1234_5678);
    dm_ack = 1'b1; tick(); dm_ack = 1'b0;
    chk("sc_result", WriteData_OUT, 32'h0000_0001);
    chk("sc_regwrite", RegWrite_OUT, 1);
    tick();

    // LHU at offset 2 and LH at offset 0
    issue(6'b101100, 32'h0000_5002, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 32'h0000_0414);
    dm_ack = 1'b1; dm_rdata = 32'h1234_ABCD; tick(); dm_ack = 1'b0;
    chk("lhu_wdata", WriteData_OUT, 32'h0000_ABCD);
    tick();
    issue(6'b101011, 32'h0000_5000, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 32'h0000_0418);
    dm_ack = 1'b1; dm_rdata = 32'h8001_7777; tick(); dm_ack = 1'b0;
    chk("lh_wdata", WriteData_OUT, 32'hFFFF_8001);
    tick();

    // LW misaligned at 0x3002
    issue(6'b111101, 32'h0000_3002, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 32'h0000_041C);
    chk("lwmis_valid", out_valid, 1);
    chk("lwmis_addr_err", addr_err, 1);
    chk("lwmis_regwrite", RegWrite_OUT, 0);
    chk("lwmis_req", dm_req, 0);
    tick();
    chk("lwmis_err_pulse", addr_err, 0);
    chk("lwmis_req_after", dm_req, 0);

    // LW with no ack: request held 4 cycles, then timeout
    issue(6'b111101, 32'h0000_6000, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 32'h0000_0420);
    for (int i = 0; i < 4; i++) begin
      chk("to_req_held", dm_req, 1);
      chk("to_no_err_yet", timeout_err, 0);
      tick();
    end
    chk("to_req_drop", dm_req, 0);
    chk("to_valid", out_valid, 1);
    chk("to_err", timeout_err, 1);
    chk("to_regwrite", RegWrite_OUT, 0);
    tick();
    chk("to_err_pulse", timeout_err, 0);

    // Ack in the last timeout cycle wins
    issue(6'b111101, 32'h0000_6004, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 32'h0000_0424);
    tick(); tick(); tick();
    dm_ack = 1'b1; dm_rdata = 32'hCAFE_F00D; tick(); dm_ack = 1'b0;
    chk("tie_valid", out_valid, 1);
    chk("tie_no_err", timeout_err, 0);
    chk("tie_wdata", WriteData_OUT, 32'hCAFE_F00D);
    chk("tie_regwrite", RegWrite_OUT, 1);
    tick();

    // LWL / SWR at offset 1
    issue(6'b101101, 32'h0000_8001, 32'hAABB_CCDD, 5'd8, 1'b1, 1'b1, 1'b0, 32'h0000_0428);
`ifdef MEM_UNALIGNED_EN
    chk("lwl_req", dm_req, 1);
    chk("lwl_addr", dm_addr, 32'h0000_8000);
    dm_ack = 1'b1; dm_rdata = 32'h1122_3344; tick(); dm_ack = 1'b0;
    chk("lwl_wdata", WriteData_OUT, 32'h2233_44DD);
    chk("lwl_no_err", addr_err, 0);
`else
    chk("lwl_addr_err", addr_err, 1);
    chk("lwl_req", dm_req, 0);
    chk("lwl_regwrite", RegWrite_OUT, 0);
`endif
    tick();
    issue(6'b110011, 32'h0000_8001, 32'hAABB_CCDD, 5'd0, 1'b1, 1'b0, 1'b1, 32'h0000_042C);
`ifdef MEM_UNALIGNED_EN
    chk("swr_be", dm_be, 4'b1100);
    chk("swr_wdata", dm_wdata, 32'hCCDD_0000);
    dm_ack = 1'b1; tick(); dm_ack = 1'b0;
    chk("swr_no_err", addr_err, 0);
`else
    chk("swr_addr_err", addr_err, 1);
    chk("swr_req", dm_req, 0);
    chk("swr_regwrite", RegWrite_OUT, 0);
`endif
    tick();

    // Asynchronous reset in the middle of ACCESS
    issue(6'b111101, 32'h0000_7000, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 32'h0000_0430);
    chk("ar_req_before", dm_req, 1);
    #3;
    RESET = 1'b0;
    #1;
    chk("ar_req_cleared", dm_req, 0);
    chk("ar_ready_low", in_ready, 0);
    chk("ar_valid_low", out_valid, 0);
    tick();
    RESET = 1'b1;
    tick();
    chk("ar_ready_back", in_ready, 1);
    chk("ar_req_stays_low", dm_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_hs.md
# mem_stage_hs

Parametrised memory-access pipeline stage sitting between EX and WB. It replaces fixed single-cycle data-memory access with a variable-latency req/ack handshake, generates byte-enables instead of a write size, and flags misaligned accesses and memory timeouts. The stage stalls the upstream pipeline while a data-memory transaction is outstanding.

## Interface
Parameters:
- ADDR_W, 32, address width.
- TIMEOUT, 255, cycles in ACCESS without `dm_ack` before abort; minimum 1.

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX presents an instruction.
- in_ready  out  1  stage can accept; equals (state==IDLE).
- Instr_IN, PC_IN  in  32  debug; registered through to Instr_OUT, PC_OUT (out, 32).
- ALU_result_IN  in  ADDR_W  address, or ALU result.
- MemWriteData_IN  in  32  rt value: store data, or merge source for LWL/LWR.
- WriteRegister_IN  in  5;  RegWrite_IN, MemRead_IN, MemWrite_IN  in  1.
- ALU_Control_IN  in  6  op code: LB 100001, LBU 101010, LH 101011, LHU 101100, LW 111101, LL 101000, LWC1 110101, LWL 101101, LWR 101110, SB 101111, SH 110000, SW 110001, SC 110110, SWL 110010, SWR 110011.
- out_valid  out  1  one-cycle pulse; result valid.
- WriteRegister_OUT  out  5;  RegWrite_OUT  out  1;  WriteData_OUT  out  32.
- dm_req, dm_we  out  1;  dm_addr  out  ADDR_W, word-aligned;  dm_wdata  out  32;  dm_be  out  4.
- dm_ack  in  1;  dm_rdata  in  32, valid in the `dm_ack` cycle.
- addr_err, timeout_err  out  1  one-cycle pulses, coincident with `out_valid`.

## Operation
- Byte order is big-endian: offset 0 = bits [31:24] = `dm_be[3]`. Offset o = `ALU_result_IN[1:0]`.
- FSM states:
  - IDLE: on `in_valid`, latch all inputs.
    - Non-memory op (MemRead=MemWrite=0): go to RESP; WriteData = ALU result.
    - Misaligned or illegal op: go to RESP with `addr_err`; RegWrite_OUT forced to 0; no `dm_req`. Misaligned means: H ops with o[0]=1; W, LL, SC, LWC1 with o≠0.
    - Otherwise: go to ACCESS.
  - ACCESS: `dm_req`=1, with `dm_addr`, `dm_we`, `dm_be`, `dm_wdata` stable until `dm_ack` is sampled high. On ack, capture and align `dm_rdata`, then go to RESP. If the timeout counter reaches TIMEOUT: deassert request, pulse `timeout_err`, force RegWrite_OUT to 0, go to RESP.
  - RESP: `out_valid`=1 for one cycle, then IDLE.
- Load alignment:
  - LB/LBU: select byte o; sign- or zero-extend.
  - LH/LHU: select half o[1]; sign- or zero-extend.
  - LW/LL/LWC1: take the whole word.
- Stores:
  - SB: `be`=1000>>o, data byte replicated ×4.
  - SH: `be`=1100>>o, half replicated ×2.
  - SW/SC: `be`=1111, data = rt.
- Stores write RegWrite_OUT=RegWrite_IN. SC WriteData = 1.
- The timeout counter is 8+ bits wide, clears on entry to ACCESS, and saturates.

## Timing
- Reset: state IDLE, all outputs 0, counter 0. `in_ready` rises one cycle after reset release. Reset during ACCESS drops `dm_req` immediately (async); the transaction is abandoned.
- Non-memory op: accepted at edge N; `out_valid` high in cycle N+1.
- Memory op: accepted at N; `dm_req` high from N+1. If ack is sampled at edge N+k, `out_valid` is high in cycle N+k+1. Zero-wait ack (k=1) gives a 3-cycle occupancy.
- `in_ready`=0 in ACCESS and RESP, so back-to-back throughput is one op per 2 cycles minimum.
- `dm_ack` while `dm_req`=0 is ignored.
- If ack and timeout occur in the same cycle, ack wins; no error.
- Outputs hold their last values between `out_valid` pulses.

## Configuration
- MEM_UNALIGNED_EN defined: LWL/LWR/SWL/SWR are supported, at any offset, via ACCESS.
  - LWL: result = (rdata<<8o) | (rt & low-8o mask).
  - LWR: result = (rdata>>8(3−o)) merged into the low 8(o+1) bits of rt.
  - SWL: `be`=1111>>o, data = rt>>8o.
  - SWR: `be`=(1111<<(3−o))&1111, data = rt<<8(3−o).
- MEM_UNALIGNED_EN undefined: these four ops are illegal. They pulse `addr_err`, produce no `dm_req`, and set RegWrite_OUT=0.

## Test plan
- ADD result 0x1234, RegWrite=1, reg 5 → `out_valid` one cycle later, WriteData_OUT=0x1234, reg 5, no `dm_req`.
- LB at 0x1001, `dm_rdata`=0x11F23344, ack after 3 wait cycles → `dm_addr`=0x1000, WriteData_OUT=0xFFFFFFF2, `out_valid` one cycle after ack, `in_ready` low throughout.
- SH at 0x2002, rt=0xAAAABEEF → `dm_we`=1, `dm_be`=0011, `dm_wdata`=0xBEEFBEEF.
- LW at 0x3002 → `addr_err` and `out_valid` pulse, RegWrite_OUT=0, `dm_req` never asserted.
- LW with no ack, TIMEOUT=4 → `dm_req` held for 4 cycles then dropped, `timeout_err` pulse, RegWrite_OUT=0; async reset mid-ACCESS clears `dm_req` without a clock edge.
- MEM_UNALIGNED_EN on: LWL at offset 1, rdata=0x11223344, rt=0xAABBCCDD → 0x223344DD. SWR at offset 1, rt=0xAABBCCDD → `be`=1100, `wdata`=0xCCDD0000. MEM_UNALIGNED_EN off: the same ops → `addr_err`.
